// File: rtl/mux_3_1_rr_sched_if.sv
// Bundle for the shared 3:1 mux scheduler: three requesters on one side,
// a single valid/ready consumer on the other.
interface mux_3_1_rr_sched_if #(
    parameter int WIDTH = 8
);
    logic [2:0]       req;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic             out_ready;
    logic [2:0]       gnt;
    logic [1:0]       sel;
    logic             out_valid;
    logic [WIDTH-1:0] y;
    logic             busy;

    modport master (
        output req, d0, d1, d2, out_ready,
        input  gnt, sel, out_valid, y, busy
    );

    modport slave (
        input  req, d0, d1, d2, out_ready,
        output gnt, sel, out_valid, y, busy
    );
endinterface

// File: rtl/mux_3_1_rr_sched.sv
// Round-robin scheduler owning the select of a shared 3:1 data mux; grants one
// requester at a time for a burst of at most MAX_BURST beats.
module mux_3_1_rr_sched #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux_3_1_rr_sched_if.slave    bus
);
    localparam int CW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01
    } state_t;

    state_t           state_r, state_s;
    logic [2:0]       gnt_r, gnt_s;
    logic [1:0]       sel_r, sel_s;
    logic [1:0]       ptr_r, ptr_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic             busy_r;
    logic             req_g_s;
    logic             out_valid_s;
    logic             beat_s;
    logic [1:0]       win_s;
    logic [WIDTH-1:0] y_s;

    function automatic logic [1:0] wrap3(input logic [2:0] v);
        case (v)
            3'd0, 3'd3: wrap3 = 2'd0;
            3'd1, 3'd4: wrap3 = 2'd1;
            3'd2, 3'd5: wrap3 = 2'd2;
            default:    wrap3 = 2'd0;
        endcase
    endfunction

    // Later assignments override earlier ones, so the nearest candidate after ptr wins.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
        logic [1:0] base;
        logic [1:0] idx;
        base    = (p > 2'd2) ? 2'd2 : p;
        rr_pick = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            idx = wrap3({1'b0, base} + 3'd1 + 3'(k));
            if (r[idx]) begin
                rr_pick = idx;
            end else begin
                rr_pick = rr_pick;
            end
        end
    endfunction

    function automatic logic [2:0] to_onehot(input logic [1:0] i);
        case (i)
            2'd0:    to_onehot = 3'b001;
            2'd1:    to_onehot = 3'b010;
            2'd2:    to_onehot = 3'b100;
            default: to_onehot = 3'b000;
        endcase
    endfunction

    // Data mux and the granted requester's request bit, both steered by sel.
    always_comb begin
        req_g_s = 1'b0;
        y_s     = bus.d0;
        case (sel_r)
            2'd0: begin
                req_g_s = bus.req[0];
                y_s     = bus.d0;
            end
            2'd1: begin
                req_g_s = bus.req[1];
                y_s     = bus.d1;
            end
            2'd2: begin
                req_g_s = bus.req[2];
                y_s     = bus.d2;
            end
            default: begin
                req_g_s = 1'b0;
                y_s     = bus.d0;
            end
        endcase
        out_valid_s = (state_r == ST_GRANT) && req_g_s;
        beat_s      = out_valid_s && bus.out_ready;
        win_s       = rr_pick(bus.req, ptr_r);
    end

    // Next-state logic: arbitrate in IDLE, count beats and release in GRANT.
    always_comb begin
        state_s = state_r;
        gnt_s   = gnt_r;
        sel_s   = sel_r;
        ptr_s   = ptr_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                gnt_s = 3'b000;
                if (bus.req != 3'b000) begin
                    state_s = ST_GRANT;
                    gnt_s   = to_onehot(win_s);
                    sel_s   = win_s;
                    cnt_s   = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (sel_r == 2'b11) begin
                    state_s = ST_IDLE;
                    gnt_s   = 3'b000;
                    sel_s   = 2'b00;
                    cnt_s   = '0;
                end else if (!req_g_s || (beat_s && (cnt_r == LAST_BEAT))) begin
                    state_s = ST_IDLE;
                    gnt_s   = 3'b000;
                    ptr_s   = sel_r;
                    cnt_s   = '0;
                end else if (beat_s) begin
                    cnt_s = cnt_r + CW'(1);
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                gnt_s   = 3'b000;
                sel_s   = 2'b00;
                cnt_s   = '0;
            end
        endcase
    end

    // State and registered outputs; reset leaves requester 0 first in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            gnt_r   <= 3'b000;
            sel_r   <= 2'b00;
            ptr_r   <= 2'd2;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            gnt_r   <= gnt_s;
            sel_r   <= sel_s;
            ptr_r   <= ptr_s;
            cnt_r   <= cnt_s;
            busy_r  <= (state_s == ST_GRANT);
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.sel       = sel_r;
    assign bus.busy      = busy_r;
    assign bus.out_valid = out_valid_s;
    assign bus.y         = y_s;
endmodule

// File: tb/tb_mux_3_1_rr_sched.sv
// Bench for mux_3_1_rr_sched: two instances (MAX_BURST 4 and 1) checked every
// cycle against a transaction-level round-robin model.
module tb_mux_3_1_rr_sched;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   req_v [2];
    logic [W-1:0] dat [3];
    logic         rdy;

    int checks = 0;
    int fails  = 0;

    // Model: owner = granted requester or -1 when idle.
    int owner [2];
    int ptr   [2];
    int msel  [2];
    int beats [2];
    int mb    [2] = '{4, 1};
    bit pending [2][3];

    int gq[$];
    int bq[$];
    logic [2:0] prev_ga = 3'b000;
    int bcnt = 0;

    always #5 clk = ~clk;

    mux_3_1_rr_sched_if #(.WIDTH(W)) bus_a ();
    mux_3_1_rr_sched_if #(.WIDTH(W)) bus_b ();

    assign bus_a.req = req_v[0];
    assign bus_b.req = req_v[1];
    assign bus_a.d0 = dat[0];
    assign bus_a.d1 = dat[1];
    assign bus_a.d2 = dat[2];
    assign bus_b.d0 = dat[0];
    assign bus_b.d1 = dat[1];
    assign bus_b.d2 = dat[2];
    assign bus_a.out_ready = rdy;
    assign bus_b.out_ready = rdy;

    mux_3_1_rr_sched #(.WIDTH(W), .MAX_BURST(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    mux_3_1_rr_sched #(.WIDTH(W), .MAX_BURST(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            owner[i] = -1;
            ptr[i]   = 2;
            msel[i]  = 0;
            beats[i] = 0;
        end
    endtask

    task automatic model_step(input int i);
        bit found;
        found = 1'b0;
        if (owner[i] < 0) begin
            for (int k = 1; k <= 3; k++) begin
                int idx;
                idx = (ptr[i] + k) % 3;
                if (!found && req_v[i][idx]) begin
                    found          = 1'b1;
                    owner[i]       = idx;
                    msel[i]        = idx;
                    beats[i]       = 0;
                    pending[i][idx] = 1'b0;
                end
            end
        end else if (!req_v[i][owner[i]]) begin
            ptr[i]   = owner[i];
            owner[i] = -1;
        end else if (rdy) begin
            beats[i]++;
            if (beats[i] == mb[i]) begin
                ptr[i]   = owner[i];
                owner[i] = -1;
            end
        end
    endtask

    task automatic check_outputs();
        logic [2:0]   og [2];
        logic [1:0]   os [2];
        logic         ov [2];
        logic [W-1:0] oy [2];
        logic         ob [2];
        logic [2:0]   eg;
        og[0] = bus_a.gnt; os[0] = bus_a.sel; ov[0] = bus_a.out_valid; oy[0] = bus_a.y; ob[0] = bus_a.busy;
        og[1] = bus_b.gnt; os[1] = bus_b.sel; ov[1] = bus_b.out_valid; oy[1] = bus_b.y; ob[1] = bus_b.busy;
        for (int i = 0; i < 2; i++) begin
            eg = (owner[i] >= 0) ? (3'b001 << owner[i]) : 3'b000;
            chk($sformatf("gnt%0d", i), og[i], eg);
            chk($sformatf("sel%0d", i), os[i], msel[i]);
            chk($sformatf("sel_legal%0d", i), (os[i] == 2'b11), 1'b0);
            chk($sformatf("valid%0d", i), ov[i], (owner[i] >= 0) && req_v[i][owner[i]]);
            chk($sformatf("y%0d", i), oy[i], dat[msel[i]]);
            chk($sformatf("busy%0d", i), ob[i], owner[i] >= 0);
        end
        if (og[0] != 3'b000) begin
            if (prev_ga == 3'b000) gq.push_back(og[0] == 3'b001 ? 0 : (og[0] == 3'b010 ? 1 : 2));
            if (ov[0] && rdy) bcnt++;
        end else if (prev_ga != 3'b000) begin
            bq.push_back(bcnt);
            bcnt = 0;
        end
        prev_ga = og[0];
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) begin
            model_step(0);
            model_step(1);
        end else begin
            model_reset();
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_req(input logic [2:0] r);
        req_v[0] = r;
        req_v[1] = r;
    endtask

    task automatic drain();
        set_req(3'b000);
        cycle();
        cycle();
    endtask

    initial begin
        int exp_order [4] = '{0, 1, 2, 0};
        rst_n = 1'b0;
        set_req(3'b000);
        rdy = 1'b0;
        dat[0] = 8'hA0; dat[1] = 8'hB1; dat[2] = 8'hC2;
        model_reset();
        for (int i = 0; i < 2; i++) for (int j = 0; j < 3; j++) pending[i][j] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        chk("rst_y_d0", bus_a.y, 8'hA0);

        // Full contention: rotation 0,1,2,0 with four beats each.
        rst_n = 1'b1;
        rdy = 1'b1;
        set_req(3'b111);
        gq.delete(); bq.delete(); bcnt = 0;
        for (int c = 0; c < 22; c++) cycle();
        for (int k = 0; k < 4; k++)
            chk($sformatf("order%0d", k), (k < gq.size()) ? gq[k] : 99, exp_order[k]);
        for (int k = 0; k < 3; k++)
            chk($sformatf("burst_len%0d", k), (k < bq.size()) ? bq[k] : 99, 4);

        // Lone requester 1: one-cycle arbitration latency then regrant.
        drain();
        set_req(3'b010);
        cycle();
        chk("arb_latency", bus_a.gnt, 3'b010);
        for (int c = 0; c < 12; c++) cycle();

        // Stalls freeze the count; release only after the fourth beat.
        drain();
        set_req(3'b001);
        cycle();
        begin
            logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
            for (int k = 0; k < 6; k++) begin
                rdy = pat[k];
                cycle();
                if (k == 4) chk("stall_still_granted", bus_a.gnt, 3'b001);
            end
        end
        chk("stall_release", bus_a.gnt, 3'b000);

        // Requester 2 drops after two beats.
        rdy = 1'b1;
        drain();
        set_req(3'b100);
        cycle();
        cycle();
        cycle();
        set_req(3'b000);
        #1;
        chk("drop_valid", bus_a.out_valid, 1'b0);
        cycle();
        chk("drop_release", bus_a.gnt, 3'b000);
        set_req(3'b101);
        cycle();
        chk("after_drop_gnt", bus_a.gnt, 3'b001);

        // Asynchronous reset in the middle of a burst to requester 1.
        drain();
        set_req(3'b010);
        cycle();
        cycle();
        cycle();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_gnt", bus_a.gnt, 3'b000);
        chk("arst_sel", bus_a.sel, 2'b00);
        chk("arst_valid", bus_a.out_valid, 1'b0);
        chk("arst_busy", bus_a.busy, 1'b0);
        cycle();
        rst_n = 1'b1;
        set_req(3'b111);
        cycle();
        chk("post_rst_gnt", bus_a.gnt, 3'b001);

        // Randomized traffic honouring the hold-until-granted contract.
        for (int i = 0; i < 2; i++) for (int j = 0; j < 3; j++) pending[i][j] = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            dat[0] = W'($urandom);
            dat[1] = W'($urandom);
            dat[2] = W'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 3; j++) begin
                    if (owner[i] == j) begin
                        req_v[i][j] = ($urandom_range(0, 9) != 0);
                    end else if (pending[i][j]) begin
                        req_v[i][j] = 1'b1;
                    end else begin
                        req_v[i][j]   = 1'($urandom_range(0, 1));
                        pending[i][j] = req_v[i][j];
                    end
                end
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/mux_3_1_rr_sched.md
Name: mux_3_1_rr_sched

Overview:
- Round-robin scheduler that shares one 3:1 data mux between three requesters and drives its select.
- Each requester presents a request and data. The block grants one requester at a time for a bounded burst, steers the mux with `sel`, and forwards beats downstream over a valid/ready handshake.
- Sits between three producer blocks and a single shared consumer.

Parameters:
- WIDTH, 8, data width of each input and the output
- MAX_BURST, 4, maximum beats per grant; legal range is 1 or more

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  3  request per requester; bit i belongs to requester i
- d0  input  WIDTH  data from requester 0
- d1  input  WIDTH  data from requester 1
- d2  input  WIDTH  data from requester 2
- out_ready  input  1  downstream accepts a beat
- gnt  output  3  one-hot grant, registered
- sel  output  2  mux select, registered: 00 selects d0, 01 selects d1, 10 selects d2
- out_valid  output  1  beat valid
- y  output  WIDTH  muxed data: d0/d1/d2 chosen by `sel`
- busy  output  1  high in GRANT state

Behaviour:
- Reset (asynchronous, rst_n = 0) takes effect immediately, mid-burst included:
  - state = IDLE, gnt = 000, sel = 00, out_valid = 0, busy = 0, beat count = 0.
  - Priority pointer = 2, so requester 0 has first priority.
  - `y` follows d0 while sel = 00.
- `sel` never takes the value 11. If an illegal state is ever reached, it returns to IDLE with sel = 00.
- State IDLE:
  - gnt = 000, out_valid = 0.
  - If req != 000, pick the winner by searching from (ptr+1) mod 3 upward with wrap.
  - On the next edge: load gnt (one-hot) and sel (winner index), clear count, enter GRANT.
  - Arbitration latency is 1 cycle from req high to gnt high.
- State GRANT, winner g:
  - out_valid = req[g] (combinational); y = mux of d0/d1/d2 by sel (combinational).
  - A beat occurs when out_valid and out_ready are both high; count increments on each beat.
  - Release: at the edge where a beat occurs with count == MAX_BURST-1, or at an edge where req[g] = 0.
  - On release: ptr <= g, gnt <= 000, enter IDLE.
  - One bubble cycle in IDLE always separates consecutive grants.
- Requests from non-granted requesters during GRANT have no effect until the next IDLE arbitration.
- Requester contract:
  - Hold req until granted.
  - Keep data stable while req[g] and out_valid are high and out_ready is low.
  - Deasserting req[g] ends the burst with no beat on that cycle.
- out_ready low stalls the burst with count frozen. A stall does not release the grant.
- MAX_BURST = 1: every grant carries exactly one beat.
- Count width: $clog2(MAX_BURST+1); no wrap within a grant.
- Simultaneous requests in IDLE: the round-robin order alone decides the winner. No requester wins twice in a row while another is requesting.

Test Plan:
- Reset then req=111, out_ready=1, MAX_BURST=4, d0=A0, d1=B1, d2=C2 -> grant order 0,1,2,0. Each grant gives 4 beats with y = A0/B1/C2. sel = 00, 01, 10. One idle cycle between grants.
- req=010 only, out_ready=1 -> gnt=010 one cycle after req. Exactly 4 beats, 1 idle cycle, then regrant to 1 since no other requester.
- Grant to 0 with out_ready toggling 1,0,0,1,1,1 -> beats only on ready-high cycles. Release after the 4th beat; count frozen during stalls.
- Granted requester 2 drops req after 2 beats -> out_valid=0 that cycle, return to IDLE, ptr=2. Next req=101 grants 0.
- rst_n asserted mid-burst (grant to 1, count=2) -> gnt=000, sel=00, out_valid=0, busy=0 immediately. After release, req=111 grants 0.
- MAX_BURST=1, req=111 -> single-beat grants rotating 0,1,2; sel never 11 over 1000 random cycles.
